// File: rtl/nebula_noc_traffic_gen.sv
`default_nettype none
// ==== nebula_noc_traffic_gen: per-node NoC traffic generator/checker; NEBULA_TGEN_LAT_EN adds latency stamps ====
// ==== Rev 1.0 ====

package nebula_noc_pkg;
  localparam int NOC_COORD_WIDTH     = 2;
  localparam int NOC_PACKET_ID_WIDTH = 8;
  localparam int NOC_PAYLOAD_WIDTH   = 32;
  localparam int NOC_VC_ID_WIDTH     = 1;
  localparam logic [1:0] FLIT_TYPE_SINGLE = 2'b11;

  typedef struct packed {
    logic [1:0]                     flit_type;
    logic [NOC_VC_ID_WIDTH-1:0]     vc_id;
    logic [NOC_COORD_WIDTH-1:0]     src_x;
    logic [NOC_COORD_WIDTH-1:0]     src_y;
    logic [NOC_COORD_WIDTH-1:0]     dest_x;
    logic [NOC_COORD_WIDTH-1:0]     dest_y;
    logic [NOC_PACKET_ID_WIDTH-1:0] packet_id;
    logic [NOC_PAYLOAD_WIDTH-1:0]   payload;
  } noc_flit_t;
endpackage

module nebula_noc_traffic_gen
  import nebula_noc_pkg::*;
#(
  parameter int MESH_SIZE_X    = 2,
  parameter int MESH_SIZE_Y    = 2,
  parameter int COORD_WIDTH    = 2,
  parameter int NODE_X         = 0,
  parameter int NODE_Y         = 0,
  parameter int CNT_WIDTH      = 16,
  parameter int GAP_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [1:0]             cfg_mode_i,
  input  logic [COORD_WIDTH-1:0] cfg_dest_x_i,
  input  logic [COORD_WIDTH-1:0] cfg_dest_y_i,
  input  logic [CNT_WIDTH-1:0]   cfg_num_packets_i,
  input  logic [GAP_WIDTH-1:0]   cfg_gap_i,
  output logic                   tx_flit_valid_o,
  input  logic                   tx_flit_ready_i,
  output noc_flit_t              tx_flit_o,
  input  logic                   rx_flit_valid_i,
  output logic                   rx_flit_ready_o,
  input  noc_flit_t              rx_flit_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   tx_timeout_o,
  output logic                   rx_err_o,
  output logic [CNT_WIDTH-1:0]   tx_count_o,
  output logic [CNT_WIDTH-1:0]   rx_ok_count_o,
  output logic [CNT_WIDTH-1:0]   rx_err_count_o,
  output logic [15:0]            lat_max_o
);

  localparam int TBL  = 1 << (2 * COORD_WIDTH);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDW  = NOC_PACKET_ID_WIDTH;
  localparam int PW   = NOC_PAYLOAD_WIDTH;
  localparam logic [PW-1:0]          SIG    = PW'(32'hDEAD0000);
  localparam logic [COORD_WIDTH-1:0] SELF_X = COORD_WIDTH'(NODE_X);
  localparam logic [COORD_WIDTH-1:0] SELF_Y = COORD_WIDTH'(NODE_Y);
  localparam logic [COORD_WIDTH-1:0] MAX_X  = COORD_WIDTH'(MESH_SIZE_X - 1);
  localparam logic [COORD_WIDTH-1:0] MAX_Y  = COORD_WIDTH'(MESH_SIZE_Y - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2, S_ERROR = 2'd3} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [COORD_WIDTH-1:0] dest_x_q, dest_x_d, dest_y_q, dest_y_d;
  logic [COORD_WIDTH-1:0] sweep_x_q, sweep_x_d, sweep_y_q, sweep_y_d;
  logic [CNT_WIDTH-1:0]   num_q, num_d, sent_q, sent_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   valid_q, valid_d, rx_ready_q, rx_ready_d;
  noc_flit_t              flit_q, flit_d;
  logic                   timeout_q, timeout_d, rx_err_q, rx_err_d;
  logic [CNT_WIDTH-1:0]   tx_cnt_q, tx_cnt_d, rx_ok_q, rx_ok_d, rx_errc_q, rx_errc_d;
  logic [IDW-1:0]         txseq_q [TBL], txseq_d [TBL];
  logic [IDW-1:0]         rxseq_q [TBL], rxseq_d [TBL];
  logic [15:0]            lat_max_q, lat_max_d;
`ifdef NEBULA_TGEN_LAT_EN
  logic [15:0]            ts_q, ts_d, lat;
`endif

  logic                   load_flit, rx_pass;
  logic [1:0]             ld_mode;
  logic [COORD_WIDTH-1:0] ld_cx, ld_cy, ld_x, ld_y;
  logic [IDW-1:0]         ld_id;
  logic [2*COORD_WIDTH-1:0] rx_src;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [2*COORD_WIDTH-1:0] idx(input logic [COORD_WIDTH-1:0] x,
                                                   input logic [COORD_WIDTH-1:0] y);
    return {y, x};
  endfunction

  always_comb begin
    state_d = state_q;  mode_d = mode_q;  dest_x_d = dest_x_q;  dest_y_d = dest_y_q;
    sweep_x_d = sweep_x_q;  sweep_y_d = sweep_y_q;  num_d = num_q;  sent_d = sent_q;
    gap_d = gap_q;  gap_cnt_d = gap_cnt_q;  wd_d = wd_q;  valid_d = valid_q;  flit_d = flit_q;
    timeout_d = timeout_q;  rx_err_d = rx_err_q;  tx_cnt_d = tx_cnt_q;
    rx_ok_d = rx_ok_q;  rx_errc_d = rx_errc_q;  lat_max_d = lat_max_q;
    txseq_d = txseq_q;  rxseq_d = rxseq_q;  rx_ready_d = 1'b1;
    load_flit = 1'b0;  ld_mode = mode_q;  ld_cx = dest_x_q;  ld_cy = dest_y_q;
    ld_x = '0;  ld_y = '0;  ld_id = '0;  rx_src = '0;  rx_pass = 1'b0;
`ifdef NEBULA_TGEN_LAT_EN
    ts_d = ts_q + 16'd1;
    lat  = '0;
`endif

    if (abort_i) begin
      state_d = S_IDLE;  valid_d = 1'b0;  wd_d = '0;  gap_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            mode_d = cfg_mode_i;  dest_x_d = cfg_dest_x_i;  dest_y_d = cfg_dest_y_i;
            num_d = cfg_num_packets_i;  gap_d = cfg_gap_i;  sent_d = '0;  wd_d = '0;
            gap_cnt_d = '0;  sweep_x_d = '0;  sweep_y_d = '0;
            tx_cnt_d = '0;  rx_ok_d = '0;  rx_errc_d = '0;
            timeout_d = 1'b0;  rx_err_d = 1'b0;  lat_max_d = '0;
            if (cfg_num_packets_i == '0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_RUN;  load_flit = 1'b1;
              ld_mode = cfg_mode_i;  ld_cx = cfg_dest_x_i;  ld_cy = cfg_dest_y_i;
            end
          end
        end
        S_RUN: begin
          if (valid_q) begin
            if (tx_flit_ready_i) begin
              txseq_d[idx(flit_q.dest_x, flit_q.dest_y)] = flit_q.packet_id + IDW'(1);
              tx_cnt_d = sat_inc(tx_cnt_q);
              wd_d     = '0;
              sent_d   = sent_q + CNT_WIDTH'(1);
              if (sent_q == num_q - CNT_WIDTH'(1)) begin
                state_d = S_DONE;  valid_d = 1'b0;
              end else begin
                if (sweep_x_q == MAX_X) begin
                  sweep_x_d = '0;
                  sweep_y_d = (sweep_y_q == MAX_Y) ? '0 : sweep_y_q + COORD_WIDTH'(1);
                end else begin
                  sweep_x_d = sweep_x_q + COORD_WIDTH'(1);
                end
                if (gap_q == '0) begin
                  load_flit = 1'b1;
                end else begin
                  valid_d = 1'b0;  gap_cnt_d = gap_q;
                end
              end
            end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
              state_d = S_ERROR;  valid_d = 1'b0;  timeout_d = 1'b1;
            end else begin
              wd_d = wd_q + WD_W'(1);
            end
          end else if (gap_cnt_q <= GAP_WIDTH'(1)) begin
            load_flit = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end

    // New flit picks its ID from the already-updated table so back-to-back same-dest packets count up.
    if (load_flit) begin
      case (ld_mode)
        2'd1:    begin ld_x = SELF_X;    ld_y = SELF_Y;    end
        2'd2:    begin ld_x = sweep_x_d; ld_y = sweep_y_d; end
        default: begin ld_x = ld_cx;     ld_y = ld_cy;     end
      endcase
      ld_id            = txseq_d[idx(ld_x, ld_y)];
      flit_d           = '0;
      flit_d.flit_type = FLIT_TYPE_SINGLE;
      flit_d.src_x     = SELF_X;
      flit_d.src_y     = SELF_Y;
      flit_d.dest_x    = ld_x;
      flit_d.dest_y    = ld_y;
      flit_d.packet_id = ld_id;
`ifdef NEBULA_TGEN_LAT_EN
      flit_d.payload   = PW'({16'hDEAD, ts_d});
`else
      flit_d.payload   = SIG + PW'(ld_id);
`endif
      valid_d = 1'b1;
    end

    if (rx_flit_valid_i && rx_ready_q) begin
      rx_src  = idx(rx_flit_i.src_x, rx_flit_i.src_y);
      rx_pass = (rx_flit_i.dest_x == SELF_X) && (rx_flit_i.dest_y == SELF_Y) &&
                (rx_flit_i.packet_id == rxseq_q[rx_src]);
`ifdef NEBULA_TGEN_LAT_EN
      rx_pass = rx_pass && (rx_flit_i.payload[PW-1 -: 16] == 16'hDEAD);
      lat     = ts_q - rx_flit_i.payload[15:0];
      if (lat > lat_max_d) lat_max_d = lat;
`else
      rx_pass = rx_pass && (rx_flit_i.payload == SIG + PW'(rx_flit_i.packet_id));
`endif
      rxseq_d[rx_src] = rx_flit_i.packet_id + IDW'(1);
      if (rx_pass) begin
        rx_ok_d = sat_inc(rx_ok_d);
      end else begin
        rx_errc_d = sat_inc(rx_errc_d);
        rx_err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  mode_q <= '0;  dest_x_q <= '0;  dest_y_q <= '0;
      sweep_x_q <= '0;  sweep_y_q <= '0;  num_q <= '0;  sent_q <= '0;
      gap_q <= '0;  gap_cnt_q <= '0;  wd_q <= '0;  valid_q <= 1'b0;  flit_q <= '0;
      rx_ready_q <= 1'b0;  timeout_q <= 1'b0;  rx_err_q <= 1'b0;
      tx_cnt_q <= '0;  rx_ok_q <= '0;  rx_errc_q <= '0;  lat_max_q <= '0;
      for (int i = 0; i < TBL; i++) begin
        txseq_q[i] <= IDW'(1);
        rxseq_q[i] <= IDW'(1);
      end
`ifdef NEBULA_TGEN_LAT_EN
      ts_q <= '0;
`endif
    end else begin
      state_q <= state_d;  mode_q <= mode_d;  dest_x_q <= dest_x_d;  dest_y_q <= dest_y_d;
      sweep_x_q <= sweep_x_d;  sweep_y_q <= sweep_y_d;  num_q <= num_d;  sent_q <= sent_d;
      gap_q <= gap_d;  gap_cnt_q <= gap_cnt_d;  wd_q <= wd_d;  valid_q <= valid_d;  flit_q <= flit_d;
      rx_ready_q <= rx_ready_d;  timeout_q <= timeout_d;  rx_err_q <= rx_err_d;
      tx_cnt_q <= tx_cnt_d;  rx_ok_q <= rx_ok_d;  rx_errc_q <= rx_errc_d;  lat_max_q <= lat_max_d;
      txseq_q <= txseq_d;  rxseq_q <= rxseq_d;
`ifdef NEBULA_TGEN_LAT_EN
      ts_q <= ts_d;
`endif
    end
  end

  logic unused_rx_fields;
  assign unused_rx_fields = ^{rx_flit_i.flit_type, rx_flit_i.vc_id};

  assign tx_flit_valid_o = valid_q;
  assign tx_flit_o       = flit_q;
  assign rx_flit_ready_o = rx_ready_q;
  assign busy_o          = (state_q == S_RUN);
  assign done_o          = (state_q == S_DONE);
  assign tx_timeout_o    = timeout_q;
  assign rx_err_o        = rx_err_q;
  assign tx_count_o      = tx_cnt_q;
  assign rx_ok_count_o   = rx_ok_q;
  assign rx_err_count_o  = rx_errc_q;
`ifdef NEBULA_TGEN_LAT_EN
  assign lat_max_o       = lat_max_q;
`else
  assign lat_max_o       = '0;
`endif

endmodule
`default_nettype wire
